mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the multi-cycle control/datapath and the byte-addressable little-endian data RAM. Accepts one memory request at a time and drives the RAM address, write data, write enable and size select. For loads, it captures the RAM read word into a memory data register with byte/half extraction and sign or zero extension. Rejects misaligned word and half accesses without touching memory, and supports a configurable number of wait states so the control unit sees a uniform start/done handshake.

## Interface
- WAIT_STATES, 0, extra ACCESS cycles inserted before the RAM edge (0..15)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- Start  in  1  request strobe; sampled only in IDLE
- Is_Store  in  1  1 = store, 0 = load
- Size  in  2  00 word, 01 half, 10 byte, 11 treated as byte
- Load_Unsigned  in  1  1 = zero-extend byte/half loads; ignored for word
- Addr_In  in  32  byte address
- Store_Data  in  32  store data; low 8/16/32 bits used per Size
- Busy  out  1  high in ACCESS
- Done  out  1  one-cycle completion pulse (DONE or ERR state)
- Misaligned  out  1  high with Done when the request was rejected
- Load_Data  out  32  extended load result; held until the next successful load
- Bad_Addr  out  32  address of the last misaligned request
- Mem_Addr  out  32  RAM address (registered request address)
- Mem_Data  out  32  RAM write data (registered Store_Data)
- Mem_W_EN  out  1  RAM write enable
- Mem_Sel  out  2  RAM size select (registered Size)
- Mem_Rd_Data  in  32  RAM combinational read word {byte+3, byte+2, byte+1, byte+0}

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, Start=1:
  - Register Addr_In, Store_Data, Size, Is_Store and Load_Unsigned.
  - Misaligned if Size=00 and Addr_In[1:0]!=0, or Size=01 and Addr_In[0]!=0 → ERR, load wait counter unused.
  - Otherwise → ACCESS with wait counter = WAIT_STATES.
- ACCESS:
  - Counter >0: decrement and stay.
  - Counter =0: final cycle → DONE.
  - Mem_W_EN = Is_Store AND final ACCESS cycle. Exactly one write edge per store.
  - Load, final cycle: at the edge, Load_Data is set from Mem_Rd_Data:
    - word: the full word
    - half: [15:0], extended by bit15 or zeros
    - byte/11: [7:0], extended by bit7 or zeros
  - Stores leave Load_Data unchanged.
- DONE: Done=1 → IDLE. Start is ignored.
- ERR: Done=1, Misaligned=1, Bad_Addr holds the registered address → IDLE. No Mem_W_EN and no change to Load_Data.
- Start held high re-issues a new request on every IDLE cycle. The control unit deasserts Start on Done.
- Mem_Addr/Mem_Data/Mem_Sel hold their last registered values outside ACCESS.
- Address arithmetic is 32-bit. There is no wrap handling here; the RAM owns +1..+3 byte offsets.

## Timing
- Reset: state IDLE; Busy, Done, Misaligned, Mem_W_EN = 0; Load_Data, Bad_Addr, Mem_Addr, Mem_Data = 0; Mem_Sel = 00; counter 0.
- Start sampled in cycle 0:
  - Aligned request: ACCESS in cycles 1..WAIT_STATES+1; Done in cycle WAIT_STATES+2.
  - Misaligned request: Done+Misaligned in cycle 1.
- Store: Mem_W_EN high only in cycle WAIT_STATES+1. The RAM writes at the end of that cycle.
- Load: Load_Data is valid from cycle WAIT_STATES+2 (the same cycle as Done).
- Next request is accepted no earlier than the cycle after Done.
- RST during ACCESS: next edge → IDLE with all outputs at reset values. A Mem_W_EN cycle coinciding with RST=1 is still presented. The RST edge clears Mem_W_EN for all later cycles.
- Start and RST in the same cycle: RST wins, and the request is dropped.

## Test plan
- WAIT_STATES=0:
  - Store word 0xDEADBEEF @0x10 → Mem_W_EN high only in cycle 1, Mem_Sel=00, Done in cycle 2.
  - Then load word @0x10 with Mem_Rd_Data=0xDEADBEEF → Load_Data=0xDEADBEEF in cycle 2.
- Byte loads with Mem_Rd_Data=0x000000F0:
  - Signed → Load_Data=0xFFFFFFF0.
  - Unsigned → 0x000000F0.
- Half loads with Mem_Rd_Data=0x12348001:
  - Signed → 0xFFFF8001.
  - Unsigned → 0x00008001.
- Misaligned requests:
  - Word @0x13 → Done+Misaligned in cycle 1, Bad_Addr=0x13, Mem_W_EN never high.
  - Half @0x21 → same behaviour.
  - Byte @0x21 → accepted.
- WAIT_STATES=3 store → Busy cycles 1-4, Mem_W_EN only in cycle 4, Done in cycle 5.
- RST asserted in cycle 2 of a WAIT_STATES=3 store → IDLE at the next edge, Mem_W_EN never high, outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response and RAM-side bundle for mem_access_unit.
//                Suffixes are from the sequencer's point of view: _i is
//                driven by the control unit or RAM, _o by the sequencer.
//  Ports       : start_i, is_store_i, size_i, load_unsigned_i, addr_in_i,
//                store_data_i, busy_o, done_o, misaligned_o, load_data_o,
//                bad_addr_o, mem_addr_o, mem_data_o, mem_w_en_o, mem_sel_o,
//                mem_rd_data_i
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;
   logic        start_i;
   logic        is_store_i;
   logic [1:0]  size_i;
   logic        load_unsigned_i;
   logic [31:0] addr_in_i;
   logic [31:0] store_data_i;
   logic        busy_o;
   logic        done_o;
   logic        misaligned_o;
   logic [31:0] load_data_o;
   logic [31:0] bad_addr_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_w_en_o;
   logic [1:0]  mem_sel_o;
   logic [31:0] mem_rd_data_i;

   // Sequencer side
   modport slave (
      input  start_i, is_store_i, size_i, load_unsigned_i, addr_in_i,
             store_data_i, mem_rd_data_i,
      output busy_o, done_o, misaligned_o, load_data_o, bad_addr_o,
             mem_addr_o, mem_data_o, mem_w_en_o, mem_sel_o
   );

   // Control unit / RAM side
   modport master (
      output start_i, is_store_i, size_i, load_unsigned_i, addr_in_i,
             store_data_i, mem_rd_data_i,
      input  busy_o, done_o, misaligned_o, load_data_o, bad_addr_o,
             mem_addr_o, mem_data_o, mem_w_en_o, mem_sel_o
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store sequencer between the control/datapath and a
//                byte-addressable little-endian data RAM. One request at a
//                time, optional wait states, misaligned word/half requests
//                rejected without a RAM access, byte/half load extraction
//                with sign or zero extension.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - mem_access_unit_if.slave (request, status, RAM bus)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
   parameter int WAIT_STATES = 0
) (
   input wire logic           clk,
   input wire logic           rst,
   mem_access_unit_if.slave   bus
);

   localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        is_store_q;
   logic        unsigned_q;
   logic        busy_q;
   logic        done_q;
   logic        misaligned_q;
   logic        mem_w_en_q;
   logic [1:0]  mem_sel_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_data_q;
   logic [31:0] load_data_q;
   logic [31:0] bad_addr_q;

   logic        w_misaligned;
   logic [31:0] load_data_d;

   assign w_misaligned = ((bus.size_i == 2'b00) && (bus.addr_in_i[1:0] != 2'b00)) ||
                         ((bus.size_i == 2'b01) && bus.addr_in_i[0]);

   // Extraction uses the registered size/extension so it is stable for the
   // whole ACCESS phase; size 11 falls through to the byte case.
   always_comb begin
      load_data_d = bus.mem_rd_data_i;
      case (mem_sel_q)
         2'b00:   load_data_d = bus.mem_rd_data_i;
         2'b01:   load_data_d = {{16{bus.mem_rd_data_i[15] & ~unsigned_q}},
                                 bus.mem_rd_data_i[15:0]};
         default: load_data_d = {{24{bus.mem_rd_data_i[7] & ~unsigned_q}},
                                 bus.mem_rd_data_i[7:0]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         is_store_q   <= 1'b0;
         unsigned_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         mem_w_en_q   <= 1'b0;
         mem_sel_q    <= 2'b00;
         mem_addr_q   <= 32'd0;
         mem_data_q   <= 32'd0;
         load_data_q  <= 32'd0;
         bad_addr_q   <= 32'd0;
      end else begin
         // Done/Misaligned are single-cycle pulses
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  mem_addr_q <= bus.addr_in_i;
                  mem_data_q <= bus.store_data_i;
                  mem_sel_q  <= bus.size_i;
                  is_store_q <= bus.is_store_i;
                  unsigned_q <= bus.load_unsigned_i;
                  if (w_misaligned) begin
                     state_q      <= S_ERR;
                     done_q       <= 1'b1;
                     misaligned_q <= 1'b1;
                     bad_addr_q   <= bus.addr_in_i;
                  end else begin
                     state_q    <= S_ACCESS;
                     cnt_q      <= C_WAIT;
                     busy_q     <= 1'b1;
                     // With no wait states the first ACCESS cycle is the final one
                     mem_w_en_q <= bus.is_store_i && (C_WAIT == 4'd0);
                  end
               end
            end
            S_ACCESS: begin
               if (cnt_q != 4'd0) begin
                  cnt_q      <= cnt_q - 4'd1;
                  // Raise the write enable for the cycle in which cnt reaches 0
                  mem_w_en_q <= is_store_q && (cnt_q == 4'd1);
               end else begin
                  state_q    <= S_DONE;
                  busy_q     <= 1'b0;
                  mem_w_en_q <= 1'b0;
                  done_q     <= 1'b1;
                  if (!is_store_q) begin
                     load_data_q <= load_data_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.misaligned_o = misaligned_q;
   assign bus.load_data_o  = load_data_q;
   assign bus.bad_addr_o   = bad_addr_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = mem_data_q;
   assign bus.mem_w_en_o   = mem_w_en_q;
   assign bus.mem_sel_o    = mem_sel_q;

endmodule
`default_nettype wire
